// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared types and constants for the beat envelope player
//
// Purpose: level-to-peak constants, envelope FSM state encoding,
// default sample width and a level-to-peak lookup helper.

package beat_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ENV_W        = 16;

  localparam logic [ENV_W-1:0] PEAK_L1 = 16'd8192;
  localparam logic [ENV_W-1:0] PEAK_L2 = 16'd16384;
  localparam logic [ENV_W-1:0] PEAK_L3 = 16'd32767;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DECAY  = 2'd2
  } state_t;

  // Level 0 never reaches the envelope (it is filtered at trigger time),
  // so mapping it to 0 is only for completeness.
  function automatic logic [ENV_W-1:0] peak_of(input logic [1:0] level);
    case (level)
      2'd1:    peak_of = PEAK_L1;
      2'd2:    peak_of = PEAK_L2;
      2'd3:    peak_of = PEAK_L3;
      default: peak_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_div.sv
// rtl/sample_tick_div.sv - free-running clock divider producing a one-cycle sample tick
//
// Purpose: counts 0..CLK_DIV-1 forever; o_tick is high while the count
// sits at CLK_DIV-1, so one tick per CLK_DIV clocks.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset (count returns to 0)
//   o_tick  one-cycle strobe, high in the last cycle of each period

module sample_tick_div #(
  parameter int CLK_DIV = 1042
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/beat_envelope_player.sv
// rtl/beat_envelope_player.sv - beat-triggered attack/decay envelope with square tone
//
// Purpose: each accepted beat pulse starts (or re-peaks) an attack/decay
// envelope; the envelope magnitude is multiplied by a +/-1 square tone and
// emitted once per sample tick.
// Ports:
//   i_clk             system clock
//   i_rst             asynchronous active-high reset
//   i_beat_en         one-cycle beat pulse
//   i_beat_intensity  beat level 0..3, qualified by i_beat_en
//   o_sample_out      signed audio sample, updated on each tick
//   o_sample_valid    one-cycle strobe marking a new o_sample_out
//   o_busy            envelope active (state != IDLE)
//   o_level_out       level of the active beat, 0 when idle

module beat_envelope_player
  import beat_pkg::*;
#(
  parameter int CLK_DIV     = 1042,
  parameter int TONE_HALF   = 55,
  parameter int DECAY_SHIFT = 5,
  parameter int SAMPLE_W    = SAMPLE_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_beat_en,
  input  logic [1:0]                 i_beat_intensity,
  output logic signed [SAMPLE_W-1:0] o_sample_out,
  output logic                       o_sample_valid,
  output logic                       o_busy,
  output logic [1:0]                 o_level_out
);

  localparam int PH_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TONE_HALF - 1);

  state_t                r_state;
  logic [ENV_W-1:0]      r_env;
  logic [ENV_W-1:0]      r_peak;
  logic [1:0]            r_level;
  logic [PH_W-1:0]       r_phase;
  logic                  r_pol;      // 1 = positive half of the tone
  logic                  r_busy;
  logic [SAMPLE_W-1:0]   r_sample;
  logic                  r_valid;

  logic                  w_tick;
  logic                  w_trig_idle;
  logic                  w_trig_busy;
  logic                  w_trigger;
  logic [ENV_W-1:0]      w_step;
  logic [ENV_W:0]        w_attack_sum;
  logic [ENV_W-1:0]      w_decay;
  logic [ENV_W-1:0]      w_env_next;
  logic [SAMPLE_W-1:0]   w_mag;
  logic                  w_phase_wrap;

  sample_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  always_comb begin
    w_trig_idle  = i_beat_en && (i_beat_intensity != 2'd0) && (r_state == ST_IDLE);
    // While active, only an equal-or-louder beat may re-peak the envelope.
    w_trig_busy  = i_beat_en && (r_state != ST_IDLE) && (i_beat_intensity >= r_level);
    w_trigger    = w_trig_idle || w_trig_busy;

    w_step       = r_peak >> 2;
    w_attack_sum = {1'b0, r_env} + {1'b0, w_step};
    // env - (env >> S) is at least 1 for any nonzero env, so only env == 0
    // needs the saturation guard.
    w_decay      = (r_env == '0) ? '0 : (r_env - (r_env >> DECAY_SHIFT) - ENV_W'(1));

    // A trigger in the same cycle as a tick freezes the envelope for that tick.
    w_env_next = r_env;
    if (!w_trigger) begin
      case (r_state)
        ST_ATTACK: w_env_next = (w_attack_sum > {1'b0, r_peak}) ? r_peak : w_attack_sum[ENV_W-1:0];
        ST_DECAY:  w_env_next = w_decay;
        default:   w_env_next = r_env;
      endcase
    end

    w_mag        = SAMPLE_W'(w_env_next);
    w_phase_wrap = (r_phase == PH_LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_peak   <= '0;
      r_level  <= 2'd0;
      r_phase  <= '0;
      r_pol    <= 1'b1;
      r_busy   <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_tick;
      if (w_tick) begin
        // Sample uses the polarity in force before this tick's tone update.
        r_sample <= r_pol ? w_mag : (SAMPLE_W'(0) - w_mag);
      end

      if (w_trigger) begin
        r_level <= i_beat_intensity;
        r_peak  <= peak_of(i_beat_intensity);
        r_state <= ST_ATTACK;
        r_busy  <= 1'b1;
        if (r_state == ST_IDLE) begin
          r_env   <= '0;
          r_phase <= '0;
          r_pol   <= 1'b1;
        end else if (w_tick) begin
          // Retrigger keeps the tone running without a phase reset.
          r_phase <= w_phase_wrap ? '0 : (r_phase + PH_W'(1));
          if (w_phase_wrap) r_pol <= ~r_pol;
        end
      end else if (w_tick) begin
        r_env <= w_env_next;
        if (r_state != ST_IDLE) begin
          r_phase <= w_phase_wrap ? '0 : (r_phase + PH_W'(1));
          if (w_phase_wrap) r_pol <= ~r_pol;
        end
        case (r_state)
          ST_ATTACK: begin
            if (w_env_next == r_peak) r_state <= ST_DECAY;
          end
          ST_DECAY: begin
            if (w_env_next == '0) begin
              r_state <= ST_IDLE;
              r_level <= 2'd0;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_sample_out   = r_sample;
  assign o_sample_valid = r_valid;
  assign o_busy         = r_busy;
  assign o_level_out    = r_level;

endmodule

// File: tb/tb_beat_envelope_player.sv
// tb/tb_beat_envelope_player.sv - directed self-checking bench for beat_envelope_player
//
// Purpose: drives beat pulses at known tick alignments (CLK_DIV=4,
// TONE_HALF=2, DECAY_SHIFT=1) and checks samples against hand-derived values.
// Ports: none (top-level bench).

module tb_beat_envelope_player;

  logic               clk;
  logic               rst;
  logic               beat_en;
  logic [1:0]         beat_intensity;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;
  logic [1:0]         level_out;

  int n_checks;
  int n_fail;

  beat_envelope_player #(
    .CLK_DIV     (4),
    .TONE_HALF   (2),
    .DECAY_SHIFT (1),
    .SAMPLE_W    (16)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_beat_en        (beat_en),
    .i_beat_intensity (beat_intensity),
    .o_sample_out     (sample_out),
    .o_sample_valid   (sample_valid),
    .o_busy           (busy),
    .o_level_out      (level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mag(input logic signed [15:0] v);
    return (v < 0) ? -int'(v) : int'(v);
  endfunction

  // Advance to the next valid sample (observed at a falling edge).
  task automatic next_sample(output logic signed [15:0] s);
    bit got;
    got = 1'b0;
    s   = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sample_valid) begin
        got = 1'b1;
        s   = sample_out;
        break;
      end
    end
    if (!got) begin
      n_fail++;
      $display("FAIL sample_timeout: no sample_valid within 16 clocks, required one");
    end
  endtask

  // Called at a falling edge; the pulse is seen by exactly one rising edge.
  task automatic pulse_beat(input logic [1:0] lvl);
    beat_en        = 1'b1;
    beat_intensity = lvl;
    @(negedge clk);
    beat_en        = 1'b0;
    beat_intensity = 2'd0;
  endtask

  task automatic drain();
    logic signed [15:0] s;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      next_sample(s);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    beat_en        = 1'b0;
    beat_intensity = 2'd0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sample: got %0d required 0", sample_out); end
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", sample_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
    if (level_out !== 2'd0)    begin n_fail++; $display("FAIL reset_level: got %0d required 0", level_out); end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    int exp_s[17] = '{2048, 4096, -6144, -8192, 4095, 2047, -1023, -511,
                      255, 127, -63, -31, 15, 7, -3, -1, 0};
    logic signed [15:0] s;
    logic signed [15:0] e;
    next_sample(s);
    pulse_beat(2'd1);
    n_checks += 2;
    if (level_out !== 2'd1) begin n_fail++; $display("FAIL single_level_start: got %0d required 1", level_out); end
    if (busy !== 1'b1)      begin n_fail++; $display("FAIL single_busy_start: got %0b required 1", busy); end
    for (int i = 0; i < 17; i++) begin
      next_sample(s);
      e = 16'(exp_s[i]);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL single_sample[%0d]: got %0d required %0d", i, s, e); end
      if (i == 15) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_before_end: got %0b required 1", busy); end
      end
    end
    n_checks += 2;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_end: got %0b required 0", busy); end
    if (level_out !== 2'd0) begin n_fail++; $display("FAIL single_level_end: got %0d required 0", level_out); end
  endtask

  task automatic test_ignored_beat();
    logic signed [15:0] s;
    next_sample(s);
    pulse_beat(2'd0);
    n_checks += 2;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL ignored_busy: got %0b required 0", busy); end
    if (level_out !== 2'd0) begin n_fail++; $display("FAIL ignored_level: got %0d required 0", level_out); end
    for (int i = 0; i < 3; i++) begin
      next_sample(s);
      n_checks += 2;
      if (s !== 16'sd0)  begin n_fail++; $display("FAIL ignored_sample[%0d]: got %0d required 0", i, s); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_busy[%0d]: got %0b required 0", i, busy); end
    end
  endtask

  task automatic test_higher_retrigger();
    int exp_m[5] = '{10238, 18429, 26620, 32767, 16383};
    logic signed [15:0] s;
    next_sample(s);
    pulse_beat(2'd1);
    for (int i = 0; i < 6; i++) next_sample(s);
    n_checks++;
    if (mag(s) != 2047) begin n_fail++; $display("FAIL higher_pre_mag: got %0d required 2047", mag(s)); end
    pulse_beat(2'd3);
    n_checks++;
    if (level_out !== 2'd3) begin n_fail++; $display("FAIL higher_level: got %0d required 3", level_out); end
    for (int i = 0; i < 5; i++) begin
      next_sample(s);
      n_checks++;
      if (mag(s) != exp_m[i]) begin n_fail++; $display("FAIL higher_mag[%0d]: got %0d required %0d", i, mag(s), exp_m[i]); end
    end
    n_checks++;
    if (level_out !== 2'd3) begin n_fail++; $display("FAIL higher_level_decay: got %0d required 3", level_out); end
    drain();
  endtask

  task automatic test_lower_retrigger();
    int exp_a[6] = '{8191, 16382, 24573, 32764, 32767, 16383};
    int exp_d[3] = '{8191, 4095, 2047};
    logic signed [15:0] s;
    next_sample(s);
    pulse_beat(2'd3);
    for (int i = 0; i < 6; i++) begin
      next_sample(s);
      n_checks++;
      if (mag(s) != exp_a[i]) begin n_fail++; $display("FAIL lower_pre_mag[%0d]: got %0d required %0d", i, mag(s), exp_a[i]); end
    end
    pulse_beat(2'd2);
    n_checks++;
    if (level_out !== 2'd3) begin n_fail++; $display("FAIL lower_level: got %0d required 3", level_out); end
    for (int i = 0; i < 3; i++) begin
      next_sample(s);
      n_checks++;
      if (mag(s) != exp_d[i]) begin n_fail++; $display("FAIL lower_mag[%0d]: got %0d required %0d", i, mag(s), exp_d[i]); end
    end
    drain();
  endtask

  task automatic test_coincident_trigger();
    logic signed [15:0] s;
    next_sample(s);
    // Three more falling edges put the pulse on the next tick edge.
    repeat (3) @(negedge clk);
    pulse_beat(2'd1);
    n_checks += 4;
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_valid: got %0b required 1", sample_valid); end
    if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL coinc_sample: got %0d required 0", sample_out); end
    if (busy !== 1'b1)         begin n_fail++; $display("FAIL coinc_busy: got %0b required 1", busy); end
    if (level_out !== 2'd1)    begin n_fail++; $display("FAIL coinc_level: got %0d required 1", level_out); end
    next_sample(s);
    n_checks++;
    if (s !== 16'sd2048) begin n_fail++; $display("FAIL coinc_next: got %0d required 2048", s); end
    drain();
  endtask

  task automatic test_reset_mid_decay();
    logic signed [15:0] s;
    next_sample(s);
    pulse_beat(2'd1);
    for (int i = 0; i < 6; i++) next_sample(s);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %0b required 1", busy); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL rstmid_sample: got %0d required 0", sample_out); end
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b required 0", sample_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
    if (level_out !== 2'd0)    begin n_fail++; $display("FAIL rstmid_level: got %0d required 0", level_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_sample(s);
      n_checks += 2;
      if (s !== 16'sd0)  begin n_fail++; $display("FAIL rstmid_post_sample[%0d]: got %0d required 0", i, s); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_busy[%0d]: got %0b required 0", i, busy); end
    end
    n_checks++;
    if (level_out !== 2'd0) begin n_fail++; $display("FAIL rstmid_post_level: got %0d required 0", level_out); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_ignored_beat();
    test_higher_retrigger();
    test_lower_retrigger();
    test_coincident_trigger();
    test_reset_mid_decay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
